mem_bist_initiator: RTL and testbench

- Initiator-side driver for the 32x16 single-port memory (addr/we/data_in in, data_out out).
- On a start pulse it writes a deterministic pattern over an address window, reads the window back, and compares.
- Reports done, a pass/fail flag, the first failing address and an error count.
- Sits between the test/control logic and the memory instance; it is the only master of the memory port while busy.

---
 rtl/mem_bist_initiator.sv | 138 +++++++++++++
 tb/tb_mem_bist_initiator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: writes a seeded address pattern over a window, reads it
// back through a latency-matched tag pipeline and reports the mismatches it sees.
module mem_bist_initiator #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HALF = DATA_W / 2;
  localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE_N = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   n_in;
  logic [2:0]        drain_cnt;
  logic              pass_q;
  logic              last_idx;
  logic              vld_pipe [RD_LAT];
  logic [ADDR_W-1:0] tag_pipe [RD_LAT];
  logic              rd_mismatch;

  // Each half of the word carries the address (or its complement), resized to DATA_W/2.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] s);
    logic [ADDR_W-1:0] na;
    logic [HALF-1:0]   hi;
    logic [HALF-1:0]   lo;
    na = ~a;
    hi = HALF'(a);
    lo = HALF'(na);
    return DATA_W'({hi, lo}) ^ s;
  endfunction

  assign n_in        = (length > MAX_N) ? MAX_N : length;
  assign last_idx    = (idx == n_q - ONE_N);
  assign mem_addr    = base_q + idx[ADDR_W-1:0];
  assign mem_we      = (state == WRITE);
  assign mem_wdata   = mem_we ? pattern(mem_addr, seed_q) : '0;
  assign busy        = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign done        = (state == DONE);
  assign pass        = done ? (err_count == 16'd0) : pass_q;
  assign rd_mismatch = vld_pipe[RD_LAT-1] &&
                       (mem_rdata != pattern(tag_pipe[RD_LAT-1], seed_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (n_in == '0) ? DONE : WRITE;
      WRITE:   if (last_idx) state_next = READ;
      READ:    if (last_idx) state_next = DRAIN;
      DRAIN:   if (drain_cnt == 3'(RD_LAT - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // idx stays at N-1 after the last read so mem_addr holds through DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      seed_q    <= '0;
      n_q       <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      pass_q    <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      drain_cnt <= '0;
      case (state)
        IDLE: if (start) begin
          base_q    <= base_addr;
          seed_q    <= seed;
          n_q       <= n_in;
          idx       <= '0;
          pass_q    <= 1'b0;
          err_addr  <= '0;
          err_count <= '0;
        end
        WRITE:   idx <= last_idx ? '0 : idx + ONE_N;
        READ:    if (!last_idx) idx <= idx + ONE_N;
        DRAIN:   drain_cnt <= drain_cnt + 3'd1;
        DONE:    pass_q <= (err_count == 16'd0);
        default: ;
      endcase
      if (rd_mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)    err_addr  <= tag_pipe[RD_LAT-1];
      end
    end
  end

  // Tags ride alongside the memory read latency so each comparison knows its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        vld_pipe[k] <= 1'b0;
        tag_pipe[k] <= '0;
      end
    end else begin
      vld_pipe[0] <= (state == READ);
      tag_pipe[0] <= mem_addr;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Bench for mem_bist_initiator: a 16-bit/RD_LAT=1 instance and an 8-bit/RD_LAT=3
// instance, each against its own behavioural memory with optional stuck-at bits.
module tb_mem_bist_initiator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic [31:0] seed;
  logic        busy, done, pass, mem_we;
  logic [15:0] err_addr, err_count, mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        s_start;
  logic [7:0]  s_base_addr;
  logic [8:0]  s_length;
  logic [31:0] s_seed;
  logic        s_busy, s_done, s_pass, s_mem_we;
  logic [7:0]  s_err_addr, s_mem_addr;
  logic [15:0] s_err_count;
  logic [31:0] s_mem_wdata, s_mem_rdata;

  int          total, bad;
  int          stuck_mode;
  logic [15:0] mon_base;
  logic [31:0] mon_seed;
  int          wr_cnt, wr_err;
  logic [7:0]  s_mon_base;
  logic [31:0] s_mon_seed;
  int          s_wr_cnt, s_wr_err;

  typedef struct {
    bit          sel;
    int          stuck;
    logic [15:0] base;
    logic [16:0] len;
    logic [31:0] seed;
    int          exp_writes;
    int          exp_cycles;
    bit          exp_pass;
    logic [15:0] exp_cnt;
    logic [15:0] exp_eaddr;
    int          restart_at;
    bit          start_in_done;
  } vec_t;

  vec_t vecs [11];

  mem_bist_initiator dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .err_addr(err_addr),
    .err_count(err_count), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_bist_initiator #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .base_addr(s_base_addr), .length(s_length),
    .seed(s_seed), .busy(s_busy), .done(s_done), .pass(s_pass), .err_addr(s_err_addr),
    .err_count(s_err_count), .mem_addr(s_mem_addr), .mem_we(s_mem_we),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat_main(input logic [15:0] a, input logic [31:0] s);
    return {a, ~a} ^ s;
  endfunction

  function automatic logic [31:0] pat_small(input logic [7:0] a, input logic [31:0] s);
    return {8'h00, a, 8'h00, ~a} ^ s;
  endfunction

  // Memory models: synchronous, read data one cycle (main) or three cycles (small) later.
  logic [31:0] mem [0:65535];
  logic [31:0] rdata_q;
  logic        stuck_bit;
  assign stuck_bit = (stuck_mode != 0 && mem_addr == 16'h0003) ||
                     (stuck_mode == 2 && mem_addr == 16'h0005);
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rdata_q <= mem[mem_addr] | {31'd0, stuck_bit};
  end
  assign mem_rdata = rdata_q;

  logic [31:0] s_mem [0:255];
  logic [31:0] s_d1, s_d2, s_d3;
  logic        s_stuck_bit;
  assign s_stuck_bit = (stuck_mode != 0) && (s_mem_addr == 8'h03);
  always @(posedge clk) begin
    if (s_mem_we) s_mem[s_mem_addr] <= s_mem_wdata;
    s_d1 <= s_mem[s_mem_addr] | {31'd0, s_stuck_bit};
    s_d2 <= s_d1;
    s_d3 <= s_d2;
  end
  assign s_mem_rdata = s_d3;

  // Every write must follow base+i with the seeded pattern.
  always @(negedge clk) begin
    if (mem_we) begin
      if (mem_addr !== mon_base + 16'(wr_cnt) || mem_wdata !== pat_main(mem_addr, mon_seed))
        wr_err++;
      wr_cnt++;
    end
    if (s_mem_we) begin
      if (s_mem_addr !== s_mon_base + 8'(s_wr_cnt) || s_mem_wdata !== pat_small(s_mem_addr, s_mon_seed))
        s_wr_err++;
      s_wr_cnt++;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string name);
    int   cycles;
    logic busy1;
    @(negedge clk);
    stuck_mode = v.stuck;
    if (!v.sel) begin
      mon_base = v.base; mon_seed = v.seed; wr_cnt = 0; wr_err = 0;
      base_addr = v.base; length = v.len; seed = v.seed; start = 1'b1;
    end else begin
      s_mon_base = v.base[7:0]; s_mon_seed = v.seed; s_wr_cnt = 0; s_wr_err = 0;
      s_base_addr = v.base[7:0]; s_length = v.len[8:0]; s_seed = v.seed; s_start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; s_start = 1'b0; cycles = 1;
    busy1 = v.sel ? s_busy : busy;
    while (!(v.sel ? s_done : done) && cycles < 1000) begin
      if (cycles == v.restart_at) begin
        start = 1'b1; base_addr = 16'h1234; seed = 32'hDEADBEEF;
      end
      @(negedge clk);
      start = 1'b0; cycles++;
    end
    check_output({name, "/done_cycle"}, 32'(cycles), 32'(v.exp_cycles));
    check_output({name, "/busy_c1"}, 32'(busy1), 32'(v.exp_writes > 0));
    check_output({name, "/pass"}, 32'(v.sel ? s_pass : pass), 32'(v.exp_pass));
    check_output({name, "/err_count"}, 32'(v.sel ? s_err_count : err_count), 32'(v.exp_cnt));
    check_output({name, "/err_addr"}, 32'(v.sel ? {8'h00, s_err_addr} : err_addr), 32'(v.exp_eaddr));
    check_output({name, "/writes"}, 32'(v.sel ? s_wr_cnt : wr_cnt), 32'(v.exp_writes));
    check_output({name, "/write_data"}, 32'(v.sel ? s_wr_err : wr_err), 32'd0);
    if (v.start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output({name, "/done_pulse"}, 32'(v.sel ? s_done : done), 32'd0);
    check_output({name, "/idle_busy"}, 32'(v.sel ? s_busy : busy), 32'd0);
    check_output({name, "/pass_hold"}, 32'(v.sel ? s_pass : pass), 32'(v.exp_pass));
  endtask

  task automatic reset_mid_read();
    bit saw_done;
    @(negedge clk);
    stuck_mode = 0; base_addr = 16'h0000; length = 17'd8; seed = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_output("abort/busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("abort/busy", 32'(busy), 32'd0);
    check_output("abort/mem_we", 32'(mem_we), 32'd0);
    check_output("abort/mem_addr", 32'(mem_addr), 32'd0);
    check_output("abort/mem_wdata", mem_wdata, 32'd0);
    check_output("abort/err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_output("abort/no_done", 32'(saw_done), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; clk = 1'b0; rst = 1'b1; stuck_mode = 0;
    start = 1'b0; base_addr = '0; length = '0; seed = '0;
    s_start = 1'b0; s_base_addr = '0; s_length = '0; s_seed = '0;
    mon_base = '0; mon_seed = '0; wr_cnt = 0; wr_err = 0;
    s_mon_base = '0; s_mon_seed = '0; s_wr_cnt = 0; s_wr_err = 0;

    //         sel  stk base      len       seed          wr   cyc  pass cnt    eaddr    rst  sid
    vecs[0]  = '{1'b0, 0, 16'h0000, 17'd8,   32'h00000000, 8,   18,  1'b1, 16'd0, 16'h0000, -1, 1'b0};
    vecs[1]  = '{1'b0, 0, 16'hFFFE, 17'd4,   32'hA5A5A5A5, 4,   10,  1'b1, 16'd0, 16'h0000, -1, 1'b0};
    vecs[2]  = '{1'b0, 1, 16'h0000, 17'd8,   32'h00000000, 8,   18,  1'b0, 16'd1, 16'h0003, -1, 1'b0};
    vecs[3]  = '{1'b0, 0, 16'h1000, 17'd0,   32'h00000000, 0,   1,   1'b1, 16'd0, 16'h0000, -1, 1'b0};
    vecs[4]  = '{1'b0, 2, 16'h0002, 17'd4,   32'h00000000, 4,   10,  1'b0, 16'd2, 16'h0003, -1, 1'b0};
    vecs[5]  = '{1'b0, 2, 16'h0000, 17'd8,   32'h00000001, 8,   18,  1'b1, 16'd0, 16'h0000, -1, 1'b0};
    vecs[6]  = '{1'b0, 0, 16'h0040, 17'd8,   32'h0F0F0000, 8,   18,  1'b1, 16'd0, 16'h0000,  3, 1'b1};
    vecs[7]  = '{1'b1, 0, 16'h0000, 17'd300, 32'h12345678, 256, 516, 1'b1, 16'd0, 16'h0000, -1, 1'b0};
    vecs[8]  = '{1'b1, 0, 16'h00F0, 17'd32,  32'h00000000, 32,  68,  1'b1, 16'd0, 16'h0000, -1, 1'b0};
    vecs[9]  = '{1'b1, 1, 16'h0000, 17'd5,   32'h00000000, 5,   14,  1'b0, 16'd1, 16'h0003, -1, 1'b0};
    vecs[10] = '{1'b1, 0, 16'h0000, 17'd0,   32'h00000000, 0,   1,   1'b1, 16'd0, 16'h0000, -1, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset/busy", 32'(busy), 32'd0);
    check_output("reset/done", 32'(done), 32'd0);
    check_output("reset/pass", 32'(pass), 32'd0);
    check_output("reset/err_addr", 32'(err_addr), 32'd0);
    check_output("reset/err_count", 32'(err_count), 32'd0);
    check_output("reset/mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset/mem_we", 32'(mem_we), 32'd0);
    check_output("reset/mem_wdata", mem_wdata, 32'd0);
    check_output("reset/small_busy", 32'(s_busy), 32'd0);

    for (int i = 0; i < 11; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    reset_mid_read();
    apply_stimulus(vecs[0], "post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
